// File: rtl/bp_bht_btb.sv
// Branch predictor for the ID stage: 2-bit bimodal BHT, tagged indirect-target BTB and a
// circular return-address stack, plus EX-stage mispredict detection and perf counters.
module bp_bht_btb #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned RAS_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  // ID-stage lookup
  input  logic        i_lk_valid,
  input  logic [31:0] i_lk_pc,
  input  logic [31:0] i_lk_imm,
  input  logic        i_lk_branch,
  input  logic        i_lk_jal,
  input  logic        i_lk_jalr,
  input  logic        i_lk_call,
  input  logic        i_lk_ret,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_pc,
  // EX-stage resolution
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_branch,
  input  logic        i_upd_jalr,
  input  logic        i_upd_taken,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_pc,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_perf_br,
  output logic [31:0] o_perf_miss
);

  localparam int unsigned BhtIw = $clog2(BHT_ENTRIES);
  localparam int unsigned BtbIw = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW  = 30 - BtbIw;
  localparam int unsigned RasPw = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned RasCw = $clog2(RAS_DEPTH + 1);

  logic [1:0]       r_bht       [BHT_ENTRIES];
  logic             r_btb_valid [BTB_ENTRIES];
  logic [TagW-1:0]  r_btb_tag   [BTB_ENTRIES];
  logic [31:0]      r_btb_tgt   [BTB_ENTRIES];
  logic [31:0]      r_ras       [RAS_DEPTH];
  logic [RasPw-1:0] r_ras_ptr;
  logic [RasCw-1:0] r_ras_cnt;
  logic [31:0]      r_perf_br;
  logic [31:0]      r_perf_miss;

  logic [BhtIw-1:0] w_lk_bht_idx;
  logic [BtbIw-1:0] w_lk_btb_idx;
  logic [1:0]       w_lk_ctr;
  logic             w_lk_btb_hit;
  logic [31:0]      w_pc_seq;
  logic [31:0]      w_pc_rel;
  logic [RasPw-1:0] w_ras_top_idx;
  logic [RasPw-1:0] w_ras_ptr_inc;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic [31:0]      w_ras_top;
  logic             w_lk_fire;
  logic             w_ras_push;
  logic             w_ras_pop;
  logic             w_ras_replace;
  logic             w_ras_wr;
  logic [RasPw-1:0] w_ras_wr_idx;

  logic [BhtIw-1:0] w_upd_bht_idx;
  logic [BtbIw-1:0] w_upd_btb_idx;
  logic [1:0]       w_upd_ctr;
  logic [1:0]       w_bht_next;
  logic             w_upd_fire;
  logic             w_bht_we;
  logic             w_btb_we;

  // ---------------------------------------------------------------- lookup
  assign w_lk_bht_idx  = i_lk_pc[BhtIw+1:2];
  assign w_lk_btb_idx  = i_lk_pc[BtbIw+1:2];
  assign w_lk_ctr      = r_bht[w_lk_bht_idx];
  assign w_lk_btb_hit  = r_btb_valid[w_lk_btb_idx] &&
                         (r_btb_tag[w_lk_btb_idx] == i_lk_pc[31:BtbIw+2]);
  assign w_pc_seq      = i_lk_pc + 32'd4;
  assign w_pc_rel      = i_lk_pc + i_lk_imm;

  // r_ras_ptr is the next free slot; the top sits one below it, modulo the depth.
  assign w_ras_top_idx = (r_ras_ptr == '0) ? RasPw'(RAS_DEPTH - 1) : r_ras_ptr - RasPw'(1);
  assign w_ras_ptr_inc = (r_ras_ptr == RasPw'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + RasPw'(1);
  assign w_ras_empty   = (r_ras_cnt == '0);
  assign w_ras_full    = (r_ras_cnt == RasCw'(RAS_DEPTH));
  assign w_ras_top     = r_ras[w_ras_top_idx];

  always_comb begin
    o_pred_taken = 1'b0;
    o_pred_pc    = w_pc_seq;
    if (i_lk_valid) begin
      if (i_lk_branch) begin
        if (w_lk_ctr[1]) begin
          o_pred_taken = 1'b1;
          o_pred_pc    = w_pc_rel;
        end
      end else if (i_lk_jal) begin
        o_pred_taken = 1'b1;
        o_pred_pc    = w_pc_rel;
      end else if (i_lk_jalr) begin
        if (i_lk_ret && !w_ras_empty) begin
          o_pred_taken = 1'b1;
          o_pred_pc    = w_ras_top;
        end else if (w_lk_btb_hit) begin
          o_pred_taken = 1'b1;
          o_pred_pc    = r_btb_tgt[w_lk_btb_idx];
        end
      end
    end
  end

  // ---------------------------------------------------------------- RAS
  assign w_lk_fire     = i_lk_valid && !i_stall && (i_lk_jal || i_lk_jalr);
  assign w_ras_push    = w_lk_fire && i_lk_call;
  assign w_ras_pop     = w_lk_fire && i_lk_ret;
  // Call+return on a non-empty stack swaps the top; on an empty stack it degrades to a push.
  assign w_ras_replace = w_ras_push && w_ras_pop && !w_ras_empty;
  assign w_ras_wr      = w_ras_push;
  assign w_ras_wr_idx  = w_ras_replace ? w_ras_top_idx : r_ras_ptr;

  always_ff @(posedge i_clk) begin
    if (w_ras_wr) begin
      r_ras[w_ras_wr_idx] <= w_pc_seq;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (w_ras_replace) begin
      r_ras_ptr <= r_ras_ptr;
      r_ras_cnt <= r_ras_cnt;
    end else if (w_ras_push) begin
      r_ras_ptr <= w_ras_ptr_inc;
      if (!w_ras_full) begin
        r_ras_cnt <= r_ras_cnt + RasCw'(1);
      end
    end else if (w_ras_pop && !w_ras_empty) begin
      r_ras_ptr <= w_ras_top_idx;
      r_ras_cnt <= r_ras_cnt - RasCw'(1);
    end
  end

  // ---------------------------------------------------------------- resolution
  assign o_mispredict  = i_upd_valid &&
                         ((i_upd_taken != i_upd_pred_taken) ||
                          (i_upd_taken && (i_upd_target != i_upd_pred_pc)));
  assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

  assign w_upd_fire    = i_upd_valid && !i_stall;
  assign w_bht_we      = w_upd_fire && i_upd_branch;
  assign w_btb_we      = w_upd_fire && i_upd_jalr && i_upd_taken;
  assign w_upd_bht_idx = i_upd_pc[BhtIw+1:2];
  assign w_upd_btb_idx = i_upd_pc[BtbIw+1:2];
  assign w_upd_ctr     = r_bht[w_upd_bht_idx];

  always_comb begin
    w_bht_next = w_upd_ctr;
    if (i_upd_taken && (w_upd_ctr != 2'b11)) begin
      w_bht_next = w_upd_ctr + 2'd1;
    end else if (!i_upd_taken && (w_upd_ctr != 2'b00)) begin
      w_bht_next = w_upd_ctr - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_bht_we) begin
      r_bht[w_upd_bht_idx] <= w_bht_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        r_btb_valid[i] <= 1'b0;
      end
    end else if (w_btb_we) begin
      r_btb_valid[w_upd_btb_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed behind a valid bit.
  always_ff @(posedge i_clk) begin
    if (w_btb_we) begin
      r_btb_tag[w_upd_btb_idx] <= i_upd_pc[31:BtbIw+2];
      r_btb_tgt[w_upd_btb_idx] <= i_upd_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_br   <= '0;
      r_perf_miss <= '0;
    end else if (w_upd_fire) begin
      r_perf_br <= r_perf_br + 32'd1;
      if (o_mispredict) begin
        r_perf_miss <= r_perf_miss + 32'd1;
      end
    end
  end

  assign o_perf_br   = r_perf_br;
  assign o_perf_miss = r_perf_miss;

endmodule

// File: doc/bp_bht_btb.md
BP_BHT_BTB -- requirements
Module: bp_bht_btb

Interface
REQ-001 Parameter BHT_ENTRIES, default 64: number of 2-bit counters; power of 2, minimum 4.
REQ-002 Parameter BTB_ENTRIES, default 16: number of indirect-target entries; power of 2, minimum 2.
REQ-003 Parameter RAS_DEPTH, default 4: return-address stack depth; minimum 2.
REQ-004 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  reset; asynchronous, active-low.
REQ-006 Port stall  in  1  when 1, no state update; outputs remain valid.
REQ-007 Port lk_valid  in  1  an ID-stage instruction is being looked up.
REQ-008 Port lk_pc  in  32  PC of the looked-up instruction.
REQ-009 Port lk_imm  in  32  sign-extended immediate of the looked-up instruction.
REQ-010 Port lk_branch, lk_jal, lk_jalr  in  1 each  instruction class; at most one is 1.
REQ-011 Port lk_call, lk_ret  in  1 each  link-register call or return hint, qualified by lk_jal or lk_jalr.
REQ-012 Port pred_taken  out  1  predicted taken.
REQ-013 Port pred_pc  out  32  predicted next PC.
REQ-014 Port upd_valid  in  1  an EX-stage resolved control instruction is present.
REQ-015 Port upd_pc, upd_target  in  32 each  resolved PC and actual target.
REQ-016 Port upd_branch, upd_jalr, upd_taken  in  1 each  class and actual outcome.
REQ-017 Port upd_pred_taken, upd_pred_pc  in  1, 32  prediction carried down the pipeline.
REQ-018 Port mispredict  out  1  resolved outcome differs from prediction.
REQ-019 Port redirect_pc  out  32  correct fetch PC when mispredict=1.
REQ-020 Port perf_br, perf_miss  out  32 each  resolved-instruction and mispredict counts.

Function
REQ-021 BHT index = pc[log2(BHT_ENTRIES)+1:2]; untagged; 2-bit counter states 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-022 BTB index = pc[log2(BTB_ENTRIES)+1:2]; each entry holds valid, tag = pc[31:log2(BTB_ENTRIES)+2], and target.
REQ-023 Prediction SHALL be combinational from lookup inputs and current state, with zero latency; if lk_valid=0, then pred_taken=0 and pred_pc=lk_pc+4.
REQ-024 Branch: pred_taken = counter[1]; pred_pc = taken ? lk_pc+lk_imm : lk_pc+4.
REQ-025 JAL: pred_taken=1; pred_pc=lk_pc+lk_imm.
REQ-026 JALR with lk_ret and a non-empty RAS: pred_taken=1; pred_pc = RAS top.
REQ-027 Other JALR, or a return with an empty RAS: on a BTB valid and tag hit, pred_taken=1 and pred_pc = BTB target; otherwise pred_taken=0 and pred_pc=lk_pc+4.
REQ-028 RAS update, gated by lk_valid & !stall: a call pushes lk_pc+4; a return pops; a call together with a return replaces the top entry, with count unchanged.
REQ-029 A push to a full RAS overwrites the oldest entry circularly, and count stays at RAS_DEPTH.
REQ-030 A pop of an empty RAS has no effect.
REQ-031 The RAS is not repaired on a mispredict.
REQ-032 mispredict = upd_valid & (upd_taken != upd_pred_taken | (upd_taken & upd_target != upd_pred_pc)); combinational; independent of stall.
REQ-033 redirect_pc = upd_taken ? upd_target : upd_pc+4.
REQ-034 BHT counter update, gated by upd_valid & upd_branch & !stall: saturating; +1 when taken, -1 when not taken.
REQ-035 BTB write, gated by upd_valid & upd_jalr & upd_taken & !stall: sets valid, tag and upd_target.
REQ-036 A lookup and an update to the same index in the same cycle: the lookup sees the pre-update value.
REQ-037 perf_br increments on each upd_valid & !stall cycle.
REQ-038 perf_miss increments on each mispredict & !stall cycle.
REQ-039 Both perf counters wrap modulo 2^32.

Reset
REQ-040 While rst=0, asynchronously: all BHT counters = 01 (WNT), all BTB valid bits = 0, RAS count = 0, RAS pointer = 0, perf_br = 0, perf_miss = 0.
REQ-041 Reset asserted mid-operation discards all predictor state immediately.
REQ-042 The first update takes effect on the first rising clk edge after rst deasserts.
REQ-043 Combinational outputs SHALL reflect the reset state during reset.

Verification
REQ-044 After reset, look up a branch at 0x100 with imm 0x20 -> pred_taken=0, pred_pc=0x104; two taken updates at 0x100 -> lookup gives pred_taken=1, pred_pc=0x120.
REQ-045 Four taken updates at 0x100, then one not-taken -> counter 10; a further update with upd_pred_taken=1, upd_taken=0 -> mispredict=1, redirect_pc=0x104, perf_miss incremented.
REQ-046 JAL call at 0x200, then JALR return -> pred_pc=0x204; a return with an empty RAS and a BTB miss -> pred_taken=0.
REQ-047 With RAS_DEPTH=4, push 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50, then pop 5 times -> 0x54, 0x44, 0x34, 0x24, then fallback prediction.
REQ-048 JALR update at 0x300 with target 0x8000 -> next lookup at 0x300 hits with pred_pc=0x8000; a lookup at 0x300 + 4*BTB_ENTRIES misses on tag.
REQ-049 Assert stall with active updates and calls -> no change to BHT, BTB, RAS or perf counters, while mispredict is still driven; assert rst=0 mid-sequence -> all state at reset values without a clock edge.
